block_interleaver: RTL and testbench

Parametrised, double-buffered bit-to-lane block interleaver. It accepts a serial bit stream, assembles frames of SYMS symbols of SYM_W bits, and emits each frame column-wise as LANES-bit words. Two ping-pong banks let one frame load while the previous frame drains, with valid/ready handshakes on both sides. It sits between the channel encoder and the symbol mapper, and it is the next generation of the fixed 16x8/4-lane interleaver.

---
 rtl/block_interleaver.sv | 138 +++++++++++++
 tb/tb_block_interleaver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_interleaver.sv
// Double-buffered bit-to-lane block interleaver: serial bits fill one bank
// while the other bank drains column-wise as LANES-bit words.
module block_interleaver #(
    parameter int SYMS  = 16,
    parameter int SYM_W = 8,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [LANES-1:0] out_bits,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             frame_err
);

    localparam int FRAME_BITS = SYMS * SYM_W;
    localparam int WORDS      = (SYMS / LANES) * SYM_W;
    localparam int WC_W       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int RC_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SI_W       = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int BI_W       = (SYM_W > 1) ? $clog2(SYM_W) : 1;

    logic [SYM_W-1:0] mem_q [2][SYMS];

    logic [WC_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [RC_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [LANES-1:0] out_bits_q, out_bits_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_err_q, frame_err_d;

    logic             accept, wr_end, rd_end, load;
    logic [SI_W-1:0]  wr_sym, rd_base;
    logic [BI_W-1:0]  wr_bit, rd_bit;
    logic [LANES-1:0] rd_word;

    assign in_ready = !rst && !full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign wr_end   = (wr_cnt_q == WC_W'(FRAME_BITS - 1));
    assign rd_end   = (rd_cnt_q == RC_W'(WORDS - 1));
    assign load     = full_q[rd_bank_q] && (!out_valid_q || out_ready);

    assign wr_sym  = SI_W'(int'(wr_cnt_q) / SYM_W);
    assign wr_bit  = BI_W'(int'(wr_cnt_q) % SYM_W);
    assign rd_base = SI_W'((int'(rd_cnt_q) / SYM_W) * LANES);
    assign rd_bit  = BI_W'(SYM_W - 1 - (int'(rd_cnt_q) % SYM_W));

    // Column read: one bit from each of LANES adjacent symbols, MSB first
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_word[k] = mem_q[rd_bank_q][rd_base + SI_W'(k)][rd_bit];
        end
    end

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        out_bits_d  = out_bits_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;

        if (accept) begin
            frame_err_d = (in_last != wr_end);
            if (wr_end) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // Reader release of the other bank may coincide with the writer's set
        if (load) begin
            out_bits_d  = rd_word;
            out_last_d  = rd_end;
            out_valid_d = 1'b1;
            if (rd_end) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][wr_sym][wr_bit] <= in_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_bits_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_bits  = out_bits_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Directed bench for block_interleaver: default 16x8/4-lane instance plus a
// reduced 8x4/2-lane instance.
module tb_block_interleaver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_bit, in_valid, in_last, in_ready;
    logic       out_valid, out_last, out_ready, frame_err;
    logic [3:0] out_bits;

    logic       s_in_bit, s_in_valid, s_in_last, s_in_ready;
    logic       s_out_valid, s_out_last, s_out_ready, s_frame_err;
    logic [1:0] s_out_bits;

    block_interleaver u_dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_bits(out_bits),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_err(frame_err)
    );

    block_interleaver #(.SYMS(8), .SYM_W(4), .LANES(2)) u_small (
        .clk(clk), .rst(rst), .in_bit(s_in_bit), .in_valid(s_in_valid),
        .in_last(s_in_last), .in_ready(s_in_ready), .out_bits(s_out_bits),
        .out_valid(s_out_valid), .out_last(s_out_last), .out_ready(s_out_ready),
        .frame_err(s_frame_err)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];
    logic [3:0] log_q[64];
    int         rx_cnt, ferr_cnt, stall_cnt;
    logic       prev_stall, prev_last, rnd_en;
    logic [3:0] prev_bits;
    logic [1:0] s_log[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference word for the default geometry: symbol s holds base+s
    function automatic logic [3:0] mword(input logic [7:0] base, input int n);
        logic [7:0] sv;
        logic [3:0] w;
        int g, b;
        g = n / 8;
        b = 7 - (n % 8);
        for (int k = 0; k < 4; k++) begin
            sv   = base + 8'(g * 4 + k);
            w[k] = sv[b];
        end
        return w;
    endfunction

    function automatic logic [1:0] sword(input int n);
        logic [3:0] sv;
        logic [1:0] w;
        int g, b;
        g = n / 4;
        b = 3 - (n % 4);
        for (int k = 0; k < 2; k++) begin
            sv   = 4'(8 + 2 * g + k);
            w[k] = sv[b];
        end
        return w;
    endfunction

    task automatic send_bit(input logic b, input logic last);
        int n = 0;
        in_bit   = b;
        in_valid = 1'b1;
        in_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 2000);
        chk("in_ready_wait", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int last_pos);
        logic [7:0] sv;
        for (int n = 0; n < 32; n++) exp_q.push_back({n == 31, mword(base, n)});
        for (int i = 0; i < 128; i++) begin
            sv = base + 8'(i / 8);
            send_bit(sv[i % 8], i == last_pos);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard, hold-while-stalled and event counters
    initial begin
        logic [4:0] e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_bits", 32'(out_bits), 32'(prev_bits));
                    chk("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && out_ready) begin
                    chk("exp_avail", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("word", 32'(out_bits), 32'(e[3:0]));
                        chk("last", 32'(out_last), 32'(e[4]));
                    end
                    if (rx_cnt < 64) log_q[rx_cnt] = out_bits;
                    rx_cnt++;
                end
                if (frame_err) ferr_cnt++;
                if (in_valid && !in_ready) stall_cnt++;
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_bits  = out_bits;
            prev_last  = out_last;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got;
        logic [3:0] sv4;
        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        s_in_bit = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        rnd_en = 1'b0; rx_cnt = 0; ferr_cnt = 0; stall_cnt = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_bits", 32'(out_bits), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single frame, symbols 0..15, with first-word latency
        send_frame(8'h00, 127);
        chk("lat_edge_e", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_edge_e1", 32'(out_valid), 1);
        wait_drain();
        chk("word0", 32'(log_q[0]), 32'h0);
        chk("word7", 32'(log_q[7]), 32'ha);
        chk("word13", 32'(log_q[13]), 32'hf);
        chk("frame1_count", 32'(rx_cnt), 32);

        // Three back-to-back frames
        rx_cnt = 0; stall_cnt = 0; ferr_cnt = 0;
        send_frame(8'h20, 127);
        send_frame(8'h55, 127);
        send_frame(8'hA3, 127);
        wait_drain();
        chk("b2b_stalls", 32'(stall_cnt), 0);
        chk("b2b_count", 32'(rx_cnt), 96);
        chk("b2b_frame_err", 32'(ferr_cnt), 0);

        // Both banks full with output stalled, then release
        rx_cnt = 0;
        out_ready = 1'b0;
        send_frame(8'h11, 127);
        send_frame(8'hC7, 127);
        fork
            send_frame(8'h6E, 127);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (in_ready || n >= 200) break;
                    n++;
                end
                chk("reopen_cycles", 32'(n), 31);
            end
        join
        wait_drain();
        chk("bp_count", 32'(rx_cnt), 96);

        // Random output backpressure
        rx_cnt = 0;
        rnd_en = 1'b1;
        fork
            begin
                send_frame(8'h3C, 127);
                wait_drain();
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        chk("rand_count", 32'(rx_cnt), 32);

        // Early in_last at bit 100 and missing in_last at bit 127
        rx_cnt = 0; ferr_cnt = 0;
        send_frame(8'h80, 100);
        wait_drain();
        chk("frame_err_pulses", 32'(ferr_cnt), 2);
        chk("ferr_count", 32'(rx_cnt), 32);

        // Reset while a frame drains and the next one is partly loaded
        out_ready = 1'b0;
        send_frame(8'hD2, 127);
        for (int i = 0; i < 60; i++) begin
            if (i == 40) out_ready = 1'b1;
            send_bit(1'(i % 3 == 0), 1'b0);
        end
        chk("draining_at_rst", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_ready", 32'(in_ready), 0);
        rst = 1'b0;
        exp_q.delete();
        rx_cnt = 0; ferr_cnt = 0;
        send_frame(8'h5A, 127);
        wait_drain();
        chk("post_rst_count", 32'(rx_cnt), 32);
        chk("post_rst_word0", 32'(log_q[0]), 0);
        chk("post_rst_ferr", 32'(ferr_cnt), 0);

        // Reduced geometry: SYMS=8, SYM_W=4, LANES=2, symbol s holds 8+s
        for (int i = 0; i < 32; i++) begin
            sv4 = 4'(8 + i / 4);
            s_in_bit   = sv4[i % 4];
            s_in_last  = (i == 31);
            s_in_valid = 1'b1;
            @(negedge clk);
            chk("s_in_ready", 32'(s_in_ready), 1);
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        n = 0; got = 0;
        while (got < 16 && n < 100) begin
            @(negedge clk);
            n++;
            if (s_out_valid) begin
                s_log[got] = s_out_bits;
                chk("s_word", 32'(s_out_bits), 32'(sword(got)));
                chk("s_last", 32'(s_out_last), 32'(got == 15));
                got++;
            end
        end
        chk("s_count", 32'(got), 16);
        chk("s_word0", 32'(s_log[0]), 32'h3);
        chk("s_word3", 32'(s_log[3]), 32'h2);
        chk("s_word10", 32'(s_log[10]), 32'h0);
        chk("s_word15", 32'(s_log[15]), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
